// File: rtl/pipeline_mac_accumulator_module.sv
// Burst accumulator behind a fixed-latency multiplier.
// Issue-side valid/last travel through a LAT-deep delay line so that they line up with
// `product`. Completed burst sums land in a one-deep ready/valid output register. A result
// that finds the register still occupied is dropped and latched into a sticky `overrun`.
module pipeline_mac_accumulator_module #(
   parameter int unsigned LAT   = 3,
   parameter int unsigned ACC_W = 24,
   parameter int unsigned CNT_W = 9
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    issue_valid,
   input  logic                    issue_last,
   input  logic                    clear,
   input  logic signed [15:0]      product,
   output logic                    sum_valid,
   input  logic                    sum_ready,
   output logic signed [ACC_W-1:0] sum,
   output logic [CNT_W-1:0]        sum_count,
   output logic                    overrun,
   output logic                    busy
);

   localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

   typedef enum logic [0:0] {
      StEmpty,
      StAccum
   } state_e;

   // Delay line: index LAT-1 is the stage aligned with `product`.
   logic [LAT-1:0] dl_valid_q, dl_valid_d;
   logic [LAT-1:0] dl_last_q, dl_last_d;

   state_e state_q, state_d;

   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;

   logic                    sum_valid_q, sum_valid_d;
   logic signed [ACC_W-1:0] sum_q, sum_d;
   logic [CNT_W-1:0]        sum_count_q, sum_count_d;
   logic                    overrun_q, overrun_d;

   logic                    al_valid;
   logic                    al_last;
   logic                    handshake;
   logic signed [ACC_W-1:0] prod_ext;
   logic [CNT_W-1:0]        cnt_sat;
   logic signed [ACC_W-1:0] res_sum;
   logic [CNT_W-1:0]        res_cnt;

   assign al_valid  = dl_valid_q[LAT-1];
   assign al_last   = dl_last_q[LAT-1];
   assign handshake = sum_valid_q & sum_ready;
   assign prod_ext  = ACC_W'(product);
   assign cnt_sat   = (cnt_q == CntMax) ? cnt_q : cnt_q + CntOne;

   // Shift issue-side valid/last toward the product-aligned stage; clear flushes the line.
   always_comb begin
      dl_valid_d    = '0;
      dl_last_d     = '0;
      dl_valid_d[0] = issue_valid;
      // `last` only means something on a valid issue.
      dl_last_d[0]  = issue_valid & issue_last;
      for (int i = 1; i < LAT; i++) begin
         dl_valid_d[i] = dl_valid_q[i-1];
         dl_last_d[i]  = dl_last_q[i-1];
      end
      if (clear) begin
         dl_valid_d = '0;
         dl_last_d  = '0;
      end
   end

   // Accumulate aligned terms, close bursts and manage the output register.
   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      sum_valid_d = sum_valid_q;
      sum_d       = sum_q;
      sum_count_d = sum_count_q;
      overrun_d   = overrun_q;
      res_sum     = '0;
      res_cnt     = '0;

      if (handshake) begin
         sum_valid_d = 1'b0;
      end

      if (al_valid) begin
         unique case (state_q)
            StEmpty: begin
               res_sum = prod_ext;
               res_cnt = CntOne;
            end
            StAccum: begin
               res_sum = acc_q + prod_ext;
               res_cnt = cnt_sat;
            end
         endcase

         if (al_last) begin
            state_d = StEmpty;
            acc_d   = '0;
            cnt_d   = '0;
            // The register is free if empty or being drained in this same cycle.
            if (!sum_valid_q || handshake) begin
               sum_valid_d = 1'b1;
               sum_d       = res_sum;
               sum_count_d = res_cnt;
            end else begin
               overrun_d = 1'b1;
            end
         end else begin
            state_d = StAccum;
            acc_d   = res_sum;
            cnt_d   = res_cnt;
         end
      end

      // Clear wins over every other event; the last delivered sum/count stay visible.
      if (clear) begin
         state_d     = StEmpty;
         acc_d       = '0;
         cnt_d       = '0;
         sum_valid_d = 1'b0;
         overrun_d   = 1'b0;
         sum_d       = sum_q;
         sum_count_d = sum_count_q;
      end
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dl_valid_q  <= '0;
         dl_last_q   <= '0;
         state_q     <= StEmpty;
         acc_q       <= '0;
         cnt_q       <= '0;
         sum_valid_q <= 1'b0;
         sum_q       <= '0;
         sum_count_q <= '0;
         overrun_q   <= 1'b0;
      end else begin
         dl_valid_q  <= dl_valid_d;
         dl_last_q   <= dl_last_d;
         state_q     <= state_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         sum_valid_q <= sum_valid_d;
         sum_q       <= sum_d;
         sum_count_q <= sum_count_d;
         overrun_q   <= overrun_d;
      end
   end

   assign sum_valid = sum_valid_q;
   assign sum       = sum_q;
   assign sum_count = sum_count_q;
   assign overrun   = overrun_q;
   assign busy      = (state_q == StAccum) | (|dl_valid_q);

endmodule
